// File: rtl/mem_access_unit.sv
// MEM-stage dcache access controller: request hold, stall, halt latch, watchdog.
// Define MEMACC_LLSC_EN to add the ll_in/sc_in ports and the LL/SC link register.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        halt_in,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic        dhit,
  input  logic [31:0] dmemload,
`ifdef MEMACC_LLSC_EN
  input  logic        ll_in,
  input  logic        sc_in,
`endif
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        memwb_writeEN,
  output logic [31:0] load_data,
  output logic        halt_out,
  output logic        wait_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] load_q, load_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        halt_q, halt_d;
  logic        werr_q, werr_d;
  logic        req;
`ifdef MEMACC_LLSC_EN
  logic        ll_q, ll_d;
  logic        sc_q, sc_d;
  logic        lv_q, lv_d;
  logic [31:0] la_q, la_d;
  logic        sc_ok;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    load_d        = load_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    halt_d        = halt_q;
    werr_d        = werr_q;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    dmemaddr      = '0;
    dmemstore     = '0;
    mem_stall     = 1'b0;
    memwb_writeEN = 1'b0;
    load_data     = '0;
    req = valid_in & (mem_read | mem_write) & ~halt_q;
`ifdef MEMACC_LLSC_EN
    ll_d  = ll_q;
    sc_d  = sc_q;
    lv_d  = lv_q;
    la_d  = la_q;
    sc_ok = lv_q & (la_q == alu_out);
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          mem_stall = 1'b1;
          addr_d    = alu_out;
          data_d    = store_data;
          rd_d      = mem_read & ~mem_write;
          wr_d      = mem_write;
          cnt_d     = '0;
          load_d    = '0;
          state_d   = ACCESS;
`ifdef MEMACC_LLSC_EN
          ll_d = ll_in & mem_read & ~mem_write;
          sc_d = sc_in & mem_write;
          // A failed SC never reaches the cache and reports 0.
          if (sc_in && mem_write && !sc_ok) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = DONE;
          end
`endif
        end else begin
          memwb_writeEN = 1'b1;
        end
      end
      ACCESS: begin
        dmemREN   = rd_q;
        dmemWEN   = wr_q;
        dmemaddr  = addr_q;
        dmemstore = data_q;
        mem_stall = 1'b1;
        if (dhit) begin
          load_d  = rd_q ? dmemload : '0;
          state_d = DONE;
`ifdef MEMACC_LLSC_EN
          if (wr_q && addr_q == la_q) lv_d = 1'b0;
          if (ll_q) begin
            lv_d = 1'b1;
            la_d = addr_q;
          end
          if (sc_q) begin
            load_d = 32'd1;
            lv_d   = 1'b0;
          end
`endif
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d >= 8'(MAX_WAIT)) werr_d = 1'b1;
      end
      DONE: begin
        memwb_writeEN = 1'b1;
        load_data     = load_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (valid_in && halt_in && memwb_writeEN) halt_d = 1'b1;
    halt_out = halt_q;
    wait_err = werr_q;
    // Outputs read as zero for the whole time reset is held.
    if (!nRST) begin
      dmemREN       = 1'b0;
      dmemWEN       = 1'b0;
      dmemaddr      = '0;
      dmemstore     = '0;
      mem_stall     = 1'b0;
      memwb_writeEN = 1'b0;
      load_data     = '0;
      halt_out      = 1'b0;
      wait_err      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      werr_q  <= 1'b0;
`ifdef MEMACC_LLSC_EN
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
      lv_q    <= 1'b0;
      la_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      werr_q  <= werr_d;
`ifdef MEMACC_LLSC_EN
      ll_q    <= ll_d;
      sc_q    <= sc_d;
      lv_q    <= lv_d;
      la_q    <= la_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle vector table plus
// watchdog/reset, halt and (when enabled) LL/SC sequences.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        valid_in, mem_read, mem_write, halt_in, dhit;
  logic [31:0] alu_out, store_data, dmemload;
  logic        ll_in = 1'b0;
  logic        sc_in = 1'b0;
  logic        dmemREN, dmemWEN, mem_stall, memwb_writeEN, halt_out, wait_err;
  logic [31:0] dmemaddr, dmemstore, load_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .valid_in(valid_in), .mem_read(mem_read), .mem_write(mem_write),
    .halt_in(halt_in), .alu_out(alu_out), .store_data(store_data),
    .dhit(dhit), .dmemload(dmemload),
`ifdef MEMACC_LLSC_EN
    .ll_in(ll_in), .sc_in(sc_in),
`endif
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall),
    .memwb_writeEN(memwb_writeEN), .load_data(load_data),
    .halt_out(halt_out), .wait_err(wait_err)
  );

  typedef struct {
    string       nm;
    logic        v, rd, wr, hl;
    logic [31:0] a, sd;
    logic        hit;
    logic [31:0] ld;
    logic [101:0] exp;
  } vec_t;

  vec_t tv[$];

  // {REN, WEN, addr, store, stall, writeEN, load_data, halt, wait_err}
  function automatic logic [101:0] ex(
    input logic ren, wen, input logic [31:0] a, s,
    input logic st, wb, input logic [31:0] ld, input logic h, we);
    return {ren, wen, a, s, st, wb, ld, h, we};
  endfunction

  function automatic vec_t mk(
    input string nm, input logic v, rd, wr, hl,
    input logic [31:0] a, sd, input logic hit,
    input logic [31:0] ld, input logic [101:0] e);
    vec_t r;
    r.nm = nm; r.v = v; r.rd = rd; r.wr = wr; r.hl = hl;
    r.a = a; r.sd = sd; r.hit = hit; r.ld = ld; r.exp = e;
    return r;
  endfunction

  task automatic drive(
    input logic v, rd, wr, hl, input logic [31:0] a, sd,
    input logic hit, input logic [31:0] ld);
    valid_in = v; mem_read = rd; mem_write = wr; halt_in = hl;
    alu_out = a; store_data = sd; dhit = hit; dmemload = ld;
  endtask

  task automatic check(input string nm, input logic [101:0] e);
    logic [101:0] g;
    @(negedge CLK);
    g = {dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
         memwb_writeEN, load_data, halt_out, wait_err};
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
    @(posedge CLK);
    #1;
  endtask

  logic [101:0] idle, stl, zero;

  initial begin
    idle = ex(0, 0, 0, 0, 0, 1, 0, 0, 0);
    stl  = ex(0, 0, 0, 0, 1, 0, 0, 0, 0);
    zero = '0;

    tv.push_back(mk("add",      1,0,0,0, 32'h0,   32'h0,   0, 32'h0, idle));
    tv.push_back(mk("bubble",   0,0,0,0, 32'h0,   32'h0,   0, 32'h0, idle));
    tv.push_back(mk("lw_req",   1,1,0,0, 32'h40,  32'h0,   0, 32'h0, stl));
    tv.push_back(mk("lw_acc1",  1,1,0,0, 32'h40,  32'h0,   0, 32'h0, ex(1,0,32'h40,0,1,0,0,0,0)));
    tv.push_back(mk("lw_acc2",  1,1,0,0, 32'h40,  32'h0,   0, 32'h0, ex(1,0,32'h40,0,1,0,0,0,0)));
    tv.push_back(mk("lw_acc3",  1,1,0,0, 32'h40,  32'h0,   1, 32'hDEADBEEF, ex(1,0,32'h40,0,1,0,0,0,0)));
    tv.push_back(mk("lw_done",  1,1,0,0, 32'h40,  32'h0,   0, 32'h0, ex(0,0,0,0,0,1,32'hDEADBEEF,0,0)));
    tv.push_back(mk("lw_after", 0,0,0,0, 32'h0,   32'h0,   0, 32'h0, idle));
    tv.push_back(mk("sw_req",   1,0,1,0, 32'h80,  32'h12345678, 0, 32'h0, stl));
    tv.push_back(mk("sw_acc1",  1,0,1,0, 32'h999, 32'hAAAA, 0, 32'h0, ex(0,1,32'h80,32'h12345678,1,0,0,0,0)));
    tv.push_back(mk("sw_acc2",  1,0,1,0, 32'h444, 32'hBBBB, 1, 32'h5, ex(0,1,32'h80,32'h12345678,1,0,0,0,0)));
    tv.push_back(mk("sw_done",  1,0,1,0, 32'h444, 32'hBBBB, 0, 32'h0, idle));
    tv.push_back(mk("rw_req",   1,1,1,0, 32'hC0,  32'h55,  0, 32'h0, stl));
    tv.push_back(mk("rw_acc",   1,1,1,0, 32'hC0,  32'h55,  1, 32'hFFFF, ex(0,1,32'hC0,32'h55,1,0,0,0,0)));
    tv.push_back(mk("rw_done",  1,1,1,0, 32'hC0,  32'h55,  0, 32'h0, idle));
    tv.push_back(mk("hit_idle", 0,0,0,0, 32'h0,   32'h0,   1, 32'h77, idle));
    tv.push_back(mk("lw2_req",  1,1,0,0, 32'h10,  32'h0,   1, 32'h77, stl));
    tv.push_back(mk("lw2_acc",  1,1,0,0, 32'h10,  32'h0,   1, 32'h0BADF00D, ex(1,0,32'h10,0,1,0,0,0,0)));
    tv.push_back(mk("lw2_done", 1,1,0,0, 32'h10,  32'h0,   0, 32'h0, ex(0,0,0,0,0,1,32'h0BADF00D,0,0)));
    tv.push_back(mk("bubble2",  0,0,0,0, 32'h0,   32'h0,   0, 32'h0, idle));

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("reset", zero);
    nRST = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].rd, tv[i].wr, tv[i].hl,
            tv[i].a, tv[i].sd, tv[i].hit, tv[i].ld);
      check(tv[i].nm, tv[i].exp);
    end

    // Watchdog: dhit withheld, request kept, then reset mid-ACCESS.
    drive(1, 1, 0, 0, 32'h200, 0, 0, 0);
    check("wd_req", stl);
    check("wd_acc1", ex(1, 0, 32'h200, 0, 1, 0, 0, 0, 0));
    repeat (3) @(posedge CLK);
    #1;
    check("wd_err", ex(1, 0, 32'h200, 0, 1, 0, 0, 0, 1));
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_mid", zero);
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("post_rst", idle);
    drive(1, 1, 0, 0, 32'h40, 0, 0, 0);
    check("post_req", stl);
    drive(1, 1, 0, 0, 32'h40, 0, 1, 32'h1234);
    check("post_acc", ex(1, 0, 32'h40, 0, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("post_done", ex(0, 0, 0, 0, 0, 1, 32'h1234, 0, 0));

`ifdef MEMACC_LLSC_EN
    ll_in = 1'b1;
    drive(1, 1, 0, 0, 32'h100, 0, 0, 0);
    check("ll_req", stl);
    drive(1, 1, 0, 0, 32'h100, 0, 1, 32'h77);
    check("ll_acc", ex(1, 0, 32'h100, 0, 1, 0, 0, 0, 0));
    check("ll_done", ex(0, 0, 0, 0, 0, 1, 32'h77, 0, 0));
    ll_in = 1'b0;
    sc_in = 1'b1;
    drive(1, 0, 1, 0, 32'h100, 32'hABC, 0, 0);
    check("sc_req", stl);
    drive(1, 0, 1, 0, 32'h100, 32'hABC, 1, 0);
    check("sc_acc", ex(0, 1, 32'h100, 32'hABC, 1, 0, 0, 0, 0));
    check("sc_done", ex(0, 0, 0, 0, 0, 1, 32'h1, 0, 0));
    drive(1, 0, 1, 0, 32'h100, 32'hDEF, 1, 0);
    check("sc2_req", stl);
    check("sc2_done", idle);
    sc_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("sc2_after", idle);
`endif

    // Halt: accepted, then a following load must not reach the cache.
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    check("halt_acc", idle);
    drive(1, 1, 0, 0, 32'h300, 0, 1, 0);
    check("halt_set", ex(0, 0, 0, 0, 0, 1, 0, 1, 0));
    check("halt_noreq", ex(0, 0, 0, 0, 0, 1, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
